ssd_bin2bcd: RTL and testbench

- Sequential binary-to-BCD converter using the shift-add-3 (double dabble) method, one iteration per clock.
- Sits directly upstream of the seven-segment display controller: it feeds that controller's four 4-bit digit inputs and its 4-bit per-digit enable mask.
- Outputs are registered and hold the last result, so the display stays stable between conversions.

---
 rtl/ssd_bin2bcd.sv | 150 +++++++++++++++
 tb/tb_ssd_bin2bcd.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3, one iteration per clock)
// feeding the seven-segment controller's digit inputs and enable mask.
module ssd_bin2bcd #(
    parameter int unsigned WIDTH    = 14,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic             stateClk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       digit0,
    output logic [3:0]       digit1,
    output logic [3:0]       digit2,
    output logic [3:0]       digit3,
    output logic [3:0]       mode
);

    localparam int unsigned CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned BW      = 16;
    localparam int unsigned MAX_BCD = 9999;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [BW-1:0]    r_bcd;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic             r_overflow;
    logic [3:0]       r_digit0;
    logic [3:0]       r_digit1;
    logic [3:0]       r_digit2;
    logic [3:0]       r_digit3;
    logic [3:0]       r_mode;

    logic [BW-1:0]    w_bcd_adj;
    logic [3:0]       w_nz;
    logic [3:0]       w_mask;
    logic             w_start_ovf;

    // Add 3 to every nibble >= 5 ahead of the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking mask from the finished accumulator.
    always_comb begin
        w_nz = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_nz[i] = (r_bcd[4*i +: 4] != 4'd0);
        end
        if (BLANK_LZ == 0) begin
            w_mask = 4'b1111;
        end else begin
            w_mask[3] = w_nz[3];
            w_mask[2] = w_nz[3] | w_nz[2];
            w_mask[1] = w_nz[3] | w_nz[2] | w_nz[1];
            w_mask[0] = 1'b1;
        end
    end

    assign w_start_ovf = (32'(value) > 32'(MAX_BCD));

    always_ff @(posedge stateClk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sr       <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_digit0   <= 4'd0;
            r_digit1   <= 4'd0;
            r_digit2   <= 4'd0;
            r_digit3   <= 4'd0;
            r_mode     <= 4'b0001;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sr    <= value;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= w_start_ovf;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= (w_bcd_adj << 1) | BW'(r_sr[WIDTH-1]);
                    r_sr  <= r_sr << 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    if (r_ovf) begin
                        r_digit0 <= 4'hF;
                        r_digit1 <= 4'hF;
                        r_digit2 <= 4'hF;
                        r_digit3 <= 4'hF;
                        r_mode   <= 4'b1111;
                    end else begin
                        r_digit0 <= r_bcd[3:0];
                        r_digit1 <= r_bcd[7:4];
                        r_digit2 <= r_bcd[11:8];
                        r_digit3 <= r_bcd[15:12];
                        r_mode   <= w_mask;
                    end
                    r_overflow <= r_ovf;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign digit0   = r_digit0;
    assign digit1   = r_digit1;
    assign digit2   = r_digit2;
    assign digit3   = r_digit3;
    assign mode     = r_mode;

endmodule

// File: tb/tb_ssd_bin2bcd.sv
// Bench for ssd_bin2bcd: table vectors, random values against a decimal model,
// and hand sequences for busy-start, FINISH-edge restart and mid-run reset.
module tb_ssd_bin2bcd;

    logic        stateClk;
    logic        rst;
    logic        start;
    logic [13:0] value;

    logic       busy, done, overflow;
    logic [3:0] digit0, digit1, digit2, digit3, mode;
    logic       nb_busy, nb_done, nb_overflow;
    logic [3:0] nb_digit0, nb_digit1, nb_digit2, nb_digit3, nb_mode;

    int nvec = 0;
    int nerr = 0;

    ssd_bin2bcd #(.WIDTH(14), .BLANK_LZ(1)) dut (
        .stateClk(stateClk), .rst(rst), .start(start), .value(value),
        .busy(busy), .done(done), .overflow(overflow),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .mode(mode)
    );

    ssd_bin2bcd #(.WIDTH(14), .BLANK_LZ(0)) dut_nb (
        .stateClk(stateClk), .rst(rst), .start(start), .value(value),
        .busy(nb_busy), .done(nb_done), .overflow(nb_overflow),
        .digit0(nb_digit0), .digit1(nb_digit1), .digit2(nb_digit2), .digit3(nb_digit3),
        .mode(nb_mode)
    );

    initial stateClk = 1'b0;
    always #5 stateClk = ~stateClk;

    typedef struct {
        logic [13:0] v;
        logic [20:0] exp;   // {overflow, mode, d3, d2, d1, d0}
    } vec_t;

    // Decimal reference: digits by division, mask from the highest nonzero digit.
    function automatic logic [20:0] model(input int v, input bit blank);
        logic [3:0] d [4];
        logic [3:0] m;
        int         top;
        if (v > 9999) return {1'b1, 4'b1111, 16'hFFFF};
        d[0] = 4'(v % 10);
        d[1] = 4'((v / 10) % 10);
        d[2] = 4'((v / 100) % 10);
        d[3] = 4'((v / 1000) % 10);
        top = 0;
        for (int i = 1; i < 4; i++) if (d[i] != 0) top = i;
        m = blank ? 4'((1 << (top + 1)) - 1) : 4'b1111;
        return {1'b0, m, d[3], d[2], d[1], d[0]};
    endfunction

    function automatic logic [20:0] got_main();
        return {overflow, mode, digit3, digit2, digit1, digit0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_conv(input logic [13:0] v);
        @(negedge stateClk);
        value = v;
        start = 1'b1;
        @(posedge stateClk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done with a cycle budget; scrambles value meanwhile.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = busy;
        for (int n = 1; n <= 30; n++) begin
            @(negedge stateClk);
            value = 14'($urandom);
            @(posedge stateClk);
            #1;
            if (done && busy) busy_ok = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_conv(input string name, input logic [13:0] v, input logic [20:0] exp);
        int lat;
        bit bok;
        start_conv(v);
        wait_done(lat, bok);
        check({name, " latency"}, 32'(lat), 32'd15);
        check({name, " busy"}, 32'(bok), 32'd1);
        check({name, " result"}, 32'(got_main()), 32'(exp));
        check({name, " nb_mode"}, 32'(nb_mode), 32'(model(int'(v), 1'b0) >> 16) & 32'hF);
        @(posedge stateClk);
        #1;
        check({name, " done_pulse"}, 32'({done, busy}), 32'd0);
    endtask

    vec_t vecs [12];

    initial begin
        int   lat;
        int   ndone;
        logic [20:0] first_res;
        logic [13:0] rv;

        vecs[0]  = '{14'd1234,  {1'b0, 4'b1111, 16'h1234}};
        vecs[1]  = '{14'd305,   {1'b0, 4'b0111, 16'h0305}};
        vecs[2]  = '{14'd7,     {1'b0, 4'b0001, 16'h0007}};
        vecs[3]  = '{14'd0,     {1'b0, 4'b0001, 16'h0000}};
        vecs[4]  = '{14'd10000, {1'b1, 4'b1111, 16'hFFFF}};
        vecs[5]  = '{14'd9999,  {1'b0, 4'b1111, 16'h9999}};
        vecs[6]  = '{14'd42,    {1'b0, 4'b0011, 16'h0042}};
        vecs[7]  = '{14'd16383, {1'b1, 4'b1111, 16'hFFFF}};
        vecs[8]  = '{14'd10,    {1'b0, 4'b0011, 16'h0010}};
        vecs[9]  = '{14'd100,   {1'b0, 4'b0111, 16'h0100}};
        vecs[10] = '{14'd1000,  {1'b0, 4'b1111, 16'h1000}};
        vecs[11] = '{14'd9,     {1'b0, 4'b0001, 16'h0009}};

        rst   = 1'b0;
        start = 1'b0;
        value = '0;
        #1 rst = 1'b1;
        #1;
        check("reset_state", 32'({busy, done, got_main()}), 32'({1'b0, 1'b0, 1'b0, 4'b0001, 16'h0000}));
        @(negedge stateClk);
        @(negedge stateClk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].v, vecs[i].exp);
        end

        for (int i = 0; i < 30; i++) begin
            rv = 14'($urandom_range(0, 16383));
            if (i % 3 == 0) rv = 14'($urandom_range(0, 120));
            run_conv($sformatf("rand%0d", i), rv, model(int'(rv), 1'b1));
        end

        // Start pulsed while busy must be ignored.
        start_conv(14'd4321);
        ndone = 0;
        lat   = -1;
        for (int n = 1; n <= 35; n++) begin
            @(negedge stateClk);
            start = (n == 5);
            if (n == 5) value = 14'd1111;
            @(posedge stateClk);
            #1;
            if (done) begin
                ndone++;
                if (lat < 0) lat = n;
            end
        end
        start = 1'b0;
        check("busy_start ndone", 32'(ndone), 32'd1);
        check("busy_start latency", 32'(lat), 32'd15);
        check("busy_start result", 32'(got_main()), 32'({1'b0, 4'b1111, 16'h4321}));

        // Start on the FINISH edge is ignored; the next edge is accepted.
        start_conv(14'd305);
        ndone = 0;
        lat   = -1;
        first_res = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge stateClk);
            start = (n == 15) || (n == 16);
            if (n == 15) value = 14'd2222;
            if (n == 16) value = 14'd77;
            @(posedge stateClk);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) first_res = got_main();
                lat = n;
            end
        end
        start = 1'b0;
        check("finish_edge ndone", 32'(ndone), 32'd2);
        check("finish_edge first", 32'(first_res), 32'({1'b0, 4'b0111, 16'h0305}));
        check("finish_edge restart_lat", 32'(lat), 32'd31);
        check("finish_edge second", 32'(got_main()), 32'({1'b0, 4'b0011, 16'h0077}));

        // Outputs hold while idle even as value moves.
        repeat (3) begin
            @(negedge stateClk);
            value = 14'($urandom);
        end
        #1;
        check("idle_hold", 32'(got_main()), 32'({1'b0, 4'b0011, 16'h0077}));

        // Reset mid-conversion: immediate reset values, no done afterwards.
        start_conv(14'd8888);
        repeat (6) @(posedge stateClk);
        #2 rst = 1'b1;
        #1;
        check("midreset outputs", 32'({busy, done, got_main()}), 32'({1'b0, 1'b0, 1'b0, 4'b0001, 16'h0000}));
        @(negedge stateClk);
        rst = 1'b0;
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge stateClk);
            #1;
            if (done || busy) ndone++;
        end
        check("midreset no_done", 32'(ndone), 32'd0);
        run_conv("after_reset", 14'd42, {1'b0, 4'b0011, 16'h0042});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
